// File: rtl/reduce_unit_seq.sv
// Multi-cycle AND/OR/XOR/NAND reduction, folding CHUNK bits per clock.
// Define REDUCE_CNT_EN to add the out_ones popcount port.
module reduce_unit_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_result
`ifdef REDUCE_CNT_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] out_ones
`endif
);

   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int PW     = NCHUNK * CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e                         state_q, state_d;
   logic [NCHUNK-1:0][CHUNK-1:0]   data_q, data_d;
   logic [1:0]                     mode_q, mode_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic                           acc_q, acc_d;
   logic                           res_q, res_d;
   logic                           vld_q, vld_d;

   logic [CHUNK-1:0] chunk;
   logic             ident;
   logic [PW-1:0]    pad;
   logic             step;
   logic             fin;

`ifdef REDUCE_CNT_EN
   localparam int OW = $clog2(WIDTH + 1);
   localparam logic [PW-1:0] VMASK = {PW{1'b1}} >> (PW - WIDTH);

   logic [NCHUNK-1:0][CHUNK-1:0] vmask;
   logic [CHUNK-1:0]             mchunk;
   logic [OW-1:0]                csum;
   logic [OW-1:0]                ones_q, ones_d;

   assign vmask  = VMASK;
   assign mchunk = vmask[cnt_q];

   // Padding bits are masked off so they never count as ones.
   always_comb begin
      csum = '0;
      for (int j = 0; j < CHUNK; j++) begin
         csum = csum + OW'(chunk[j] & mchunk[j]);
      end
   end

   assign out_ones = ones_q;
`endif

   assign chunk = data_q[cnt_q];
   assign ident = ~(in_mode[1] ^ in_mode[0]);

   always_comb begin
      pad = {PW{ident}};
      pad[WIDTH-1:0] = in_data;
   end

   always_comb begin
      case (mode_q)
         2'b01:   step = acc_q | (|chunk);
         2'b10:   step = acc_q ^ (^chunk);
         default: step = acc_q & (&chunk);
      endcase
      fin = (mode_q == 2'b11) ? ~step : step;
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      res_d   = res_q;
      vld_d   = vld_q;
`ifdef REDUCE_CNT_EN
      ones_d  = ones_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = pad;
               mode_d  = in_mode;
               acc_d   = ident;
               cnt_d   = '0;
`ifdef REDUCE_CNT_EN
               ones_d  = '0;
`endif
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d = step;
`ifdef REDUCE_CNT_EN
            ones_d = ones_q + csum;
`endif
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               res_d   = fin;
               vld_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         mode_q  <= '0;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         res_q   <= 1'b0;
         vld_q   <= 1'b0;
`ifdef REDUCE_CNT_EN
         ones_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
`ifdef REDUCE_CNT_EN
         ones_q  <= ones_d;
`endif
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = vld_q;
   assign out_result = res_q;

endmodule

// File: tb/tb_reduce_unit_seq.sv
// Directed bench for reduce_unit_seq: a 16/4 instance and a padded 10/4 instance.
module tb_reduce_unit_seq;

   logic clk = 1'b0;
   logic rst_n;

   logic        v16, ir16, ov16, rdy16, r16;
   logic [15:0] d16;
   logic [1:0]  m16;
   logic        v10, ir10, ov10, rdy10, r10;
   logic [9:0]  d10;
   logic [1:0]  m10;
`ifdef REDUCE_CNT_EN
   logic [4:0]  ones16;
   logic [3:0]  ones10;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   reduce_unit_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (v16),
      .in_ready   (ir16),
      .in_data    (d16),
      .in_mode    (m16),
      .out_valid  (ov16),
      .out_ready  (rdy16),
      .out_result (r16)
`ifdef REDUCE_CNT_EN
      ,
      .out_ones   (ones16)
`endif
   );

   reduce_unit_seq #(.WIDTH(10), .CHUNK(4)) dut10 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (v10),
      .in_ready   (ir10),
      .in_data    (d10),
      .in_mode    (m10),
      .out_valid  (ov10),
      .out_ready  (rdy10),
      .out_result (r10)
`ifdef REDUCE_CNT_EN
      ,
      .out_ones   (ones10)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full transaction with out_ready held high.
   task automatic op(input bit w10, input logic [15:0] d,
                     input logic [1:0] m, input logic exp,
                     input string tag);
      int n;
      int lat;
      logic ov;
      logic rs;
      lat = w10 ? 3 : 4;
      @(negedge clk);
      chk({tag, "/ready"}, 32'(w10 ? ir10 : ir16), 32'd1);
      if (w10) begin
         v10 = 1'b1; d10 = d[9:0]; m10 = m;
      end else begin
         v16 = 1'b1; d16 = d; m16 = m;
      end
      @(posedge clk); #1;
      v16 = 1'b0;
      v10 = 1'b0;
      n = 0;
      ov = w10 ? ov10 : ov16;
      while (!ov && n < 20) begin
         @(posedge clk); #1;
         n++;
         ov = w10 ? ov10 : ov16;
      end
      rs = w10 ? r10 : r16;
      chk({tag, "/lat"}, 32'(n), 32'(lat));
      chk({tag, "/res"}, 32'(rs), 32'(exp));
`ifdef REDUCE_CNT_EN
      chk({tag, "/ones"}, w10 ? 32'(ones10) : 32'(ones16),
          32'($countones(w10 ? {6'd0, d[9:0]} : d)));
`endif
      @(posedge clk); #1;
      chk({tag, "/drop"}, 32'(w10 ? ov10 : ov16), 32'd0);
   endtask

   logic [15:0] sd [5];
   logic [1:0]  sm [5];
   logic        se [5];
   time         ta [5];

   initial begin
      int n;
      rst_n = 1'b0;
      v16 = 1'b0; d16 = '0; m16 = '0; rdy16 = 1'b1;
      v10 = 1'b0; d10 = '0; m10 = '0; rdy10 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst/ir16", 32'(ir16), 32'd1);
      chk("rst/ov16", 32'(ov16), 32'd0);
      chk("rst/r16",  32'(r16),  32'd0);
      chk("rst/ir10", 32'(ir10), 32'd1);
      chk("rst/ov10", 32'(ov10), 32'd0);
`ifdef REDUCE_CNT_EN
      chk("rst/ones", 32'(ones16), 32'd0);
`endif
      rst_n = 1'b1;

      op(0, 16'hFFFF, 2'b00, 1'b1, "and_ffff");
      op(0, 16'hFFFE, 2'b00, 1'b0, "and_fffe");
      op(0, 16'h0000, 2'b01, 1'b0, "or_0000");
      op(0, 16'h0100, 2'b01, 1'b1, "or_0100");
      op(0, 16'h0101, 2'b10, 1'b0, "xor_0101");
      op(0, 16'h0111, 2'b10, 1'b1, "xor_0111");
      op(0, 16'hFFFF, 2'b11, 1'b0, "nand_ffff");
      op(0, 16'hF0F1, 2'b01, 1'b1, "or_f0f1");
      for (int p = 0; p < 16; p++) begin
         op(0, {12'hFFF, 4'(p)}, 2'b00, (p == 15), "sweep");
      end

      op(1, 16'h03FF, 2'b00, 1'b1, "p_and_3ff");
      op(1, 16'h0000, 2'b01, 1'b0, "p_or_000");
      op(1, 16'h0001, 2'b10, 1'b1, "p_xor_001");
      op(1, 16'h03FF, 2'b11, 1'b0, "p_nand_3ff");
      op(1, 16'h0200, 2'b01, 1'b1, "p_or_200");

      // Back-pressure with the operand disturbed while held.
      rdy16 = 1'b0;
      @(negedge clk);
      v16 = 1'b1; d16 = 16'h0007; m16 = 2'b10;
      @(posedge clk); #1;
      v16 = 1'b0;
      n = 0;
      while (!ov16 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp/lat", 32'(n), 32'd4);
      for (int i = 0; i < 8; i++) begin
         chk("bp/ov", 32'(ov16), 32'd1);
         chk("bp/res", 32'(r16), 32'd1);
         chk("bp/ir", 32'(ir16), 32'd0);
         d16 = 16'($urandom);
         m16 = 2'(i);
         v16 = 1'b1;
         if (i < 7) begin
            @(posedge clk); #1;
         end
      end
      v16 = 1'b0;
      rdy16 = 1'b1;
      @(posedge clk); #1;
      chk("bp/ov_clr", 32'(ov16), 32'd0);
      chk("bp/ir_ret", 32'(ir16), 32'd1);

      // Reset two cycles into an operation.
      @(negedge clk);
      v16 = 1'b1; d16 = 16'hFFFF; m16 = 2'b00;
      @(posedge clk); #1;
      v16 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mr/busy", 32'(ir16), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mr/ov", 32'(ov16), 32'd0);
      chk("mr/ir", 32'(ir16), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      op(0, 16'h8000, 2'b01, 1'b1, "mr_or_8000");

      // Streaming with in_valid held high.
      sd[0] = 16'hFFFF; sm[0] = 2'b00; se[0] = 1'b1;
      sd[1] = 16'h0000; sm[1] = 2'b01; se[1] = 1'b0;
      sd[2] = 16'h0111; sm[2] = 2'b10; se[2] = 1'b1;
      sd[3] = 16'h1234; sm[3] = 2'b11; se[3] = 1'b1;
      sd[4] = 16'h0003; sm[4] = 2'b10; se[4] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         d16 = sd[i]; m16 = sm[i]; v16 = 1'b1;
         n = 0;
         while (!ir16 && n < 20) begin
            @(negedge clk);
            n++;
         end
         @(posedge clk);
         ta[i] = $time;
         #1;
         n = 0;
         while (!ov16 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         chk("st/lat", 32'(n), 32'd4);
         chk("st/res", 32'(r16), 32'(se[i]));
         if (i > 0) chk("st/period", 32'(ta[i] - ta[i-1]), 32'd60);
      end
      v16 = 1'b0;
      @(posedge clk); #1;
      chk("st/ov_clr", 32'(ov16), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("st/no_dup", 32'(ov16), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
